poly_inbuf_addr_gen: RTL and testbench



---
 rtl/poly_pkg.sv | 28 ++
 rtl/poly_phase_acc.sv | 48 ++++
 rtl/poly_inbuf_addr_gen.sv | 135 +++++++++++++
 tb/tb_poly_inbuf_addr_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polyphase resampler input-buffer address generator:
// sequencer state encoding and derived-parameter helpers.
package poly_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PROC = 2'd1,
    COPY = 2'd2
  } state_t;

  function automatic int calc_q(input int m, input int l);
    return m / l;
  endfunction

  function automatic int calc_r(input int m, input int l);
    return m % l;
  endfunction

  function automatic int calc_hist(input int taps);
    return taps - 1;
  endfunction

  // A one-phase resampler still needs a 1-bit phase port.
  function automatic int clog2_min1(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/poly_phase_acc.sv
// Rational L/M phase accumulator: tracks the newest input sample (n) and the
// coefficient phase (ph) of the next output, with block rebase by BLK.
module poly_phase_acc
  import poly_pkg::*;
#(
  parameter int L      = 3,
  parameter int M      = 4,
  parameter int N_W    = 11,
  parameter int PH_W   = 2,
  parameter int N_INIT = 21,
  parameter int BLK    = 768
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            rebase,
  output logic [N_W-1:0]  n,
  output logic [N_W-1:0]  n_next,
  output logic [PH_W-1:0] ph
);

  localparam int Q = calc_q(M, L);
  localparam int R = calc_r(M, L);

  logic [PH_W:0]   ph_sum;
  logic            wrap;
  logic [PH_W-1:0] ph_next;

  assign ph_sum  = {1'b0, ph} + (PH_W+1)'(R);
  assign wrap    = (ph_sum >= (PH_W+1)'(L));
  assign ph_next = wrap ? PH_W'(ph_sum - (PH_W+1)'(L)) : PH_W'(ph_sum);
  assign n_next  = n + N_W'(Q) + N_W'(wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n  <= N_W'(N_INIT);
      ph <= '0;
    end else if (load) begin
      n  <= N_W'(N_INIT);
      ph <= '0;
    end else if (step) begin
      n  <= rebase ? (n_next - N_W'(BLK)) : n_next;
      ph <= ph_next;
    end
  end

endmodule

// File: rtl/poly_inbuf_addr_gen.sv
// Input ping-buffer sequencer for an L/M polyphase resampler: fills the buffer,
// walks the FIR read window per output, then copies tail history to the head.
module poly_inbuf_addr_gen
  import poly_pkg::*;
#(
  parameter int L       = 3,
  parameter int M       = 4,
  parameter int TAPS_PP = 22,
  parameter int BLK     = 768,
  parameter int ADDR_W  = 10,
  localparam int PH_W   = clog2_min1(L)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PH_W-1:0]   fir_phase,
  output logic              fir_tap_valid,
  output logic              fir_first,
  output logic              fir_last,
  input  logic              fir_ready,
  output logic              block_start,
  output logic              copy_end
);

  localparam int HIST = calc_hist(TAPS_PP);
  localparam int LAST = HIST + BLK - 1;
  localparam int N_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] HIST_A  = ADDR_W'(HIST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);
  localparam logic [ADDR_W-1:0] KLAST_A = ADDR_W'(TAPS_PP - 1);
  localparam logic [ADDR_W-1:0] BLK_A   = ADDR_W'(BLK);
  localparam logic [N_W-1:0]    LAST_N  = N_W'(LAST);

  if ((HIST + BLK > 2**ADDR_W) || (L < 1) || (M < 1) || (TAPS_PP < 2) || (BLK < TAPS_PP))
  begin : g_cfg_check
    $error("poly_inbuf_addr_gen: illegal parameter combination");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, k, c;
  logic [N_W-1:0]    n, n_next;
  logic [PH_W-1:0]   ph;
  logic              fill_acc, fill_done, last_tap, tap_acc, step, rebase;
  logic              copy_wr, copy_done;

  assign fill_acc  = (state == FILL) && in_valid;
  assign fill_done = fill_acc && (wptr == LAST_A);
  assign last_tap  = (k == KLAST_A);
  assign tap_acc   = (state == PROC) && fir_ready;
  assign step      = tap_acc && last_tap;
  assign rebase    = step && (n_next > LAST_N);
  // Copy writes trail their reads by one cycle to cover RAM read latency.
  assign copy_wr   = (state == COPY) && (c != '0);
  assign copy_done = (state == COPY) && (c == HIST_A);

  poly_phase_acc #(
    .L      (L),
    .M      (M),
    .N_W    (N_W),
    .PH_W   (PH_W),
    .N_INIT (HIST),
    .BLK    (BLK)
  ) u_acc (
    .clk    (sys_clk),
    .rst    (reset),
    .load   (1'b0),
    .step   (step),
    .rebase (rebase),
    .n      (n),
    .n_next (n_next),
    .ph     (ph)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wptr <= HIST_A;
      k    <= '0;
      c    <= '0;
    end else begin
      if (copy_done)     wptr <= HIST_A;
      else if (fill_acc) wptr <= wptr + ADDR_W'(1);
      if (fill_done)     k <= '0;
      else if (tap_acc)  k <= last_tap ? '0 : k + ADDR_W'(1);
      if (rebase)                c <= '0;
      else if (state == COPY)    c <= c + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = (state == FILL);
    wr_en         = fill_acc | copy_wr;
    wr_sel        = copy_wr;
    wr_addr       = '0;
    rd_addr       = '0;
    fir_phase     = '0;
    fir_tap_valid = 1'b0;
    fir_first     = 1'b0;
    fir_last      = 1'b0;
    block_start   = fill_done;
    copy_end      = copy_done;

    if (fill_acc)     wr_addr = wptr;
    else if (copy_wr) wr_addr = c - ADDR_W'(1);

    case (state)
      FILL: if (fill_done) state_nxt = PROC;
      PROC: begin
        fir_tap_valid = 1'b1;
        rd_addr       = ADDR_W'(n - N_W'(k));
        fir_phase     = ph;
        fir_first     = (k == '0);
        fir_last      = last_tap;
        if (rebase) state_nxt = COPY;
      end
      COPY: begin
        if (c != HIST_A) rd_addr = BLK_A + c;
        if (copy_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: tb/tb_poly_inbuf_addr_gen.sv
// Bench for poly_inbuf_addr_gen: small (2/3) and default (3/4) configurations,
// checked cycle by cycle against an absolute-time resampler reference.
module tb_poly_inbuf_addr_gen;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_s, rst_d, in_valid, fir_ready;

  logic       s_in_ready, s_wr_en, s_wr_sel, s_tv, s_ff, s_fl, s_bs, s_ce;
  logic [3:0] s_wr_addr, s_rd_addr;
  logic [0:0] s_ph;

  logic       d_in_ready, d_wr_en, d_wr_sel, d_tv, d_ff, d_fl, d_bs, d_ce;
  logic [9:0] d_wr_addr, d_rd_addr;
  logic [1:0] d_ph;

  poly_inbuf_addr_gen #(.L(2), .M(3), .TAPS_PP(3), .BLK(8), .ADDR_W(4)) u_small (
    .sys_clk(sys_clk), .reset(rst_s), .in_valid(in_valid), .in_ready(s_in_ready),
    .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr), .rd_addr(s_rd_addr),
    .fir_phase(s_ph), .fir_tap_valid(s_tv), .fir_first(s_ff), .fir_last(s_fl),
    .fir_ready(fir_ready), .block_start(s_bs), .copy_end(s_ce)
  );

  poly_inbuf_addr_gen u_dflt (
    .sys_clk(sys_clk), .reset(rst_d), .in_valid(in_valid), .in_ready(d_in_ready),
    .wr_en(d_wr_en), .wr_sel(d_wr_sel), .wr_addr(d_wr_addr), .rd_addr(d_rd_addr),
    .fir_phase(d_ph), .fir_tap_valid(d_tv), .fir_first(d_ff), .fir_last(d_fl),
    .fir_ready(fir_ready), .block_start(d_bs), .copy_end(d_ce)
  );

  // Observed outputs of whichever instance is under test.
  logic        sel;
  logic [31:0] o_in_ready, o_wr_en, o_wr_sel, o_wr_addr, o_rd_addr, o_ph;
  logic [31:0] o_tv, o_ff, o_fl, o_bs, o_ce;

  always_comb begin
    if (sel) begin
      o_in_ready = 32'(d_in_ready); o_wr_en = 32'(d_wr_en); o_wr_sel = 32'(d_wr_sel);
      o_wr_addr  = 32'(d_wr_addr);  o_rd_addr = 32'(d_rd_addr); o_ph = 32'(d_ph);
      o_tv = 32'(d_tv); o_ff = 32'(d_ff); o_fl = 32'(d_fl); o_bs = 32'(d_bs); o_ce = 32'(d_ce);
    end else begin
      o_in_ready = 32'(s_in_ready); o_wr_en = 32'(s_wr_en); o_wr_sel = 32'(s_wr_sel);
      o_wr_addr  = 32'(s_wr_addr);  o_rd_addr = 32'(s_rd_addr); o_ph = 32'(s_ph);
      o_tv = 32'(s_tv); o_ff = 32'(s_ff); o_fl = 32'(s_fl); o_bs = 32'(s_bs); o_ce = 32'(s_ce);
    end
  end

  int cL, cM, cT, cB, cH;
  int checks = 0;
  int errors = 0;

  // Reference: output j sits at absolute input position j*M/L with phase (j*M)%L.
  typedef struct { int addr; int ph; int fst; int lst; } tap_t;
  tap_t q[$];
  int   j_abs, blk, exp_outs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_d = v;
    else     rst_s = v;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 1);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_wr_sel"}, o_wr_sel, 0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
    chk({tag, "_rd_addr"}, o_rd_addr, 0);
    chk({tag, "_phase"}, o_ph, 0);
    chk({tag, "_tap_valid"}, o_tv, 0);
    chk({tag, "_first"}, o_ff, 0);
    chk({tag, "_last"}, o_fl, 0);
    chk({tag, "_block_start"}, o_bs, 0);
    chk({tag, "_copy_end"}, o_ce, 0);
  endtask

  task automatic build_block();
    q.delete();
    exp_outs = 0;
    while ((j_abs * cM) / cL < cB * (blk + 1)) begin
      int pos;
      pos = (j_abs * cM) / cL;
      for (int t = 0; t < cT; t++)
        q.push_back('{addr: cH + pos - cB * blk - t, ph: (j_abs * cM) % cL,
                      fst: int'(t == 0), lst: int'(t == cT - 1)});
      j_abs++;
      exp_outs++;
    end
  endtask

  task automatic do_fill(input bit rand_iv);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    while (cnt < cB && guard < 8 * cB) begin
      in_valid  = rand_iv ? ($urandom_range(3) != 0) : 1'b1;
      fir_ready = 1'($urandom_range(1));
      #2;
      chk("fill_in_ready", o_in_ready, 1);
      chk("fill_tap_valid", o_tv, 0);
      if (in_valid) begin
        chk("fill_wr_en", o_wr_en, 1);
        chk("fill_wr_sel", o_wr_sel, 0);
        chk("fill_wr_addr", o_wr_addr, cH + cnt);
        chk("fill_block_start", o_bs, int'(cnt == cB - 1));
        cnt++;
      end else begin
        chk("fill_idle_wr_en", o_wr_en, 0);
        chk("fill_idle_block_start", o_bs, 0);
      end
      guard++;
      tick();
    end
  endtask

  task automatic do_proc(input bit bp_dir, input bit hold_iv);
    int lasts, firsts, guard, stall, outs;
    tap_t e;
    lasts = 0; firsts = 0; guard = 0; stall = 2;
    build_block();
    outs = exp_outs;
    while (q.size() > 0 && guard < 4 * cT * outs + 100) begin
      e = q[0];
      in_valid = hold_iv ? 1'b1 : 1'($urandom_range(1));
      if (bp_dir && e.addr == 4 && e.ph == 0 && stall > 0) begin
        fir_ready = 1'b0;
        stall--;
      end else begin
        fir_ready = bp_dir ? 1'b1 : ($urandom_range(7) != 0);
      end
      #2;
      chk("proc_tap_valid", o_tv, 1);
      chk("proc_rd_addr", o_rd_addr, e.addr);
      chk("proc_phase", o_ph, e.ph);
      chk("proc_first", o_ff, e.fst);
      chk("proc_last", o_fl, e.lst);
      chk("proc_in_ready", o_in_ready, 0);
      chk("proc_wr_en", o_wr_en, 0);
      chk("proc_block_start", o_bs, 0);
      if (fir_ready) begin
        if (o_fl == 1) lasts++;
        if (o_ff == 1) firsts++;
        void'(q.pop_front());
      end
      guard++;
      tick();
    end
    if (q.size() != 0) chk("proc_timeout_taps_left", q.size(), 0);
    chk("proc_fir_last_count", lasts, outs);
    chk("proc_fir_first_count", firsts, outs);
    blk++;
  endtask

  task automatic do_copy(input bit hold_iv, input int abort_at);
    for (int c = 0; c <= cH; c++) begin
      in_valid  = hold_iv ? 1'b1 : 1'($urandom_range(1));
      fir_ready = 1'($urandom_range(1));
      #2;
      if (c == abort_at) begin
        in_valid = 1'b0;
        set_rst(1'b1);
        #1;
        chk_idle("abort");
        @(negedge sys_clk);
        set_rst(1'b0);
        j_abs = 0;
        blk = 0;
        return;
      end
      chk("copy_tap_valid", o_tv, 0);
      chk("copy_in_ready", o_in_ready, 0);
      chk("copy_end", o_ce, int'(c == cH));
      chk("copy_wr_en", o_wr_en, int'(c > 0));
      chk("copy_wr_sel", o_wr_sel, int'(c > 0));
      if (c < cH) chk("copy_rd_addr", o_rd_addr, cB + c);
      if (c > 0)  chk("copy_wr_addr", o_wr_addr, c - 1);
      tick();
    end
  endtask

  initial begin
    rst_s = 1'b1; rst_d = 1'b1; in_valid = 1'b0; fir_ready = 1'b0; sel = 1'b0;
    cL = 2; cM = 3; cT = 3; cB = 8; cH = 2;
    j_abs = 0; blk = 0;
    @(negedge sys_clk);
    #2;
    chk_idle("reset_held_small");
    @(negedge sys_clk);
    rst_s = 1'b0;
    #2;
    chk_idle("reset_small");
    @(negedge sys_clk);

    do_fill(1'b0); do_proc(1'b1, 1'b1); do_copy(1'b1, -1);
    do_fill(1'b1); do_proc(1'b0, 1'b0); do_copy(1'b0, -1);
    do_fill(1'b1); do_proc(1'b0, 1'b1); do_copy(1'b0, 1);
    do_fill(1'b1); do_proc(1'b0, 1'b0); do_copy(1'b0, -1);

    rst_s = 1'b1;
    sel = 1'b1;
    cL = 3; cM = 4; cT = 22; cB = 768; cH = 21;
    j_abs = 0; blk = 0;
    @(negedge sys_clk);
    rst_d = 1'b0;
    #2;
    chk_idle("reset_default");
    @(negedge sys_clk);
    do_fill(1'b1); do_proc(1'b0, 1'b1); do_copy(1'b1, -1);
    do_fill(1'b1); do_proc(1'b0, 1'b0); do_copy(1'b0, -1);
    do_fill(1'b1); do_proc(1'b0, 1'b0); do_copy(1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
